mcpu_mem_tlb: RTL and testbench

- Instruction-side TLB and page-table walker.
- Responds to the cache-to-TLB lookup interface: the virtual page comes in, and the physical page plus flags go out.
- Fully associative translation store with round-robin replacement.
- On a miss, walks a two-level page table by issuing read atoms to the memory arbiter, installs the result, then reports ready.

---
 rtl/mcpu_mem_tlb.sv | 204 ++++++++++++++++++++
 tb/tb_mcpu_mem_tlb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_mem_tlb.sv
// mcpu_mem_tlb: instruction-side TLB with a two-level page-table walker.
//
// A lookup is accepted when tlb_re and tlb_ready are both high. A hit in the
// fully associative store, or any lookup with paging disabled, answers on the
// next cycle. A miss walks the L1 and L2 tables through read atoms to the
// memory arbiter. A present L2 PTE is then installed at the round-robin
// pointer, and the result is reported with tlb_ready.
//
// Ports:
//   clkrst_mem_clk / clkrst_mem_rst : clock, asynchronous active-high reset
//   tlb_addr, tlb_re                : lookup virtual page and request
//   tlb_phys_addr, tlb_flags        : result of the last accepted lookup
//   tlb_ready                       : result valid / ready for a new lookup
//   tlb_ptb, tlb_paging_en          : L1 table page and paging enable
//                                     (sampled at accept)
//   tlb_flush                       : invalidate all entries
//   tlb2arb_*                       : read-atom interface to the memory arbiter
//
// Optional: define MCPU_MEM_TLB_STATS_EN to add the saturating outputs
// tlb_hit_count and tlb_miss_count.
//
// States:
//   IDLE   | ready; accepts lookups, answers hits and identity translations
//   L1_REQ | read atom for the L1 PTE, held until rvalid
//   L2_REQ | read atom for the L2 PTE, held until rvalid; installs on present
//   FAULT  | L1 PTE not present; reports phys=0 and flags=0
//   DONE   | reports the walked L2 PTE
module mcpu_mem_tlb #(
  parameter int NUM_ENTRIES = 8,
  parameter int ENTRY_BITS  = 3
) (
  input  logic         clkrst_mem_clk,
  input  logic         clkrst_mem_rst,
  input  logic [19:0]  tlb_addr,
  input  logic         tlb_re,
  output logic [3:0]   tlb_flags,
  output logic [19:0]  tlb_phys_addr,
  output logic         tlb_ready,
  input  logic [19:0]  tlb_ptb,
  input  logic         tlb_paging_en,
  input  logic         tlb_flush,
  output logic         tlb2arb_valid,
  output logic [2:0]   tlb2arb_opcode,
  output logic [26:0]  tlb2arb_addr,
  output logic [255:0] tlb2arb_wdata,
  output logic [31:0]  tlb2arb_wbe,
  input  logic [255:0] tlb2arb_rdata,
  input  logic         tlb2arb_rvalid,
`ifdef MCPU_MEM_TLB_STATS_EN
  output logic [31:0]  tlb_hit_count,
  output logic [31:0]  tlb_miss_count,
`endif
  input  logic         tlb2arb_stall
);

  typedef enum logic [2:0] {S_IDLE, S_L1_REQ, S_L2_REQ, S_FAULT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [19:0]           tag_q [NUM_ENTRIES];
  logic [19:0]           ppn_q [NUM_ENTRIES];
  logic [3:0]            flg_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] vld_q;
  logic [ENTRY_BITS-1:0] ptr_q;
  logic [19:0]           va_q;
  logic [19:0]           ptb_q;
  logic [31:0]           pte_q;
  logic                  flush_seen_q;

  logic                  accept, hit, install;
  logic [19:0]           hit_ppn;
  logic [3:0]            hit_flg;
  logic [2:0]            word_sel;
  logic [31:0]           rword;

  assign accept = tlb_re && tlb_ready && (state == S_IDLE);

  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    hit_flg = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (vld_q[i] && tag_q[i] == tlb_addr) begin
        hit     = 1'b1;
        hit_ppn = ppn_q[i];
        hit_flg = flg_q[i];
      end
    end
  end

  // The PTE is the 32-bit word picked out of the line by byte-address bits [4:2].
  assign word_sel = (state == S_L1_REQ) ? va_q[12:10] : va_q[2:0];
  assign rword    = tlb2arb_rdata[{word_sel, 5'd0} +: 32];

  // A flush seen at any point of the walk (or on the install edge) blocks the install.
  assign install = (state == S_L2_REQ) && tlb2arb_rvalid && rword[0] &&
                   !flush_seen_q && !tlb_flush;

  always_comb begin
    state_nxt     = state;
    tlb2arb_valid = 1'b0;
    tlb2arb_addr  = '0;
    case (state)
      S_IDLE:   if (accept && tlb_paging_en && !hit) state_nxt = S_L1_REQ;
      S_L1_REQ: begin
        tlb2arb_valid = 1'b1;
        tlb2arb_addr  = {ptb_q, va_q[19:13]};
        if (tlb2arb_rvalid) state_nxt = rword[0] ? S_L2_REQ : S_FAULT;
      end
      S_L2_REQ: begin
        tlb2arb_valid = 1'b1;
        tlb2arb_addr  = {pte_q[31:12], va_q[9:3]};
        if (tlb2arb_rvalid) state_nxt = S_DONE;
      end
      S_FAULT:  state_nxt = S_IDLE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign tlb2arb_opcode = 3'd0;
  assign tlb2arb_wdata  = '0;
  assign tlb2arb_wbe    = '0;

  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      state         <= S_IDLE;
      tlb_ready     <= 1'b1;
      tlb_phys_addr <= '0;
      tlb_flags     <= '0;
      va_q          <= '0;
      ptb_q         <= '0;
      pte_q         <= '0;
      flush_seen_q  <= 1'b0;
      vld_q         <= '0;
      ptr_q         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          va_q         <= tlb_addr;
          ptb_q        <= tlb_ptb;
          flush_seen_q <= tlb_flush;
          if (!tlb_paging_en) begin
            tlb_phys_addr <= tlb_addr;
            tlb_flags     <= 4'hF;
          end else if (hit) begin
            tlb_phys_addr <= hit_ppn;
            tlb_flags     <= hit_flg;
          end else begin
            tlb_ready <= 1'b0;
          end
        end
        S_L1_REQ, S_L2_REQ: begin
          flush_seen_q <= flush_seen_q | tlb_flush;
          if (tlb2arb_rvalid) pte_q <= rword;
        end
        S_FAULT: begin
          tlb_ready     <= 1'b1;
          tlb_phys_addr <= '0;
          tlb_flags     <= '0;
        end
        S_DONE: begin
          tlb_ready     <= 1'b1;
          tlb_phys_addr <= pte_q[31:12];
          tlb_flags     <= pte_q[3:0];
        end
        default: ;
      endcase
      if (install) begin
        vld_q[ptr_q] <= 1'b1;
        ptr_q        <= ptr_q + ENTRY_BITS'(1);
      end
      if (tlb_flush) vld_q <= '0;
    end
  end

  // Tag/data storage needs no reset; the valid bits guard it.
  always_ff @(posedge clkrst_mem_clk) begin
    if (install) begin
      tag_q[ptr_q] <= va_q;
      ppn_q[ptr_q] <= rword[31:12];
      flg_q[ptr_q] <= rword[3:0];
    end
  end

`ifdef MCPU_MEM_TLB_STATS_EN
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      tlb_hit_count  <= '0;
      tlb_miss_count <= '0;
    end else if (accept && tlb_paging_en) begin
      if (hit && tlb_hit_count != 32'hFFFF_FFFF)
        tlb_hit_count <= tlb_hit_count + 32'd1;
      if (!hit && tlb_miss_count != 32'hFFFF_FFFF)
        tlb_miss_count <= tlb_miss_count + 32'd1;
    end
  end
`endif

  // The stall input is advisory and PTE bits [11:4] carry nothing for translation.
  logic unused_ok;
  assign unused_ok = ^{tlb2arb_stall, pte_q[11:4]};

endmodule

// File: tb/tb_mcpu_mem_tlb.sv
module tb_mcpu_mem_tlb;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  addr;
  logic         re;
  logic [3:0]   flags;
  logic [19:0]  phys;
  logic         ready;
  logic [19:0]  ptb;
  logic         paging_en;
  logic         flush;
  logic         arb_valid;
  logic [2:0]   arb_opcode;
  logic [26:0]  arb_addr;
  logic [255:0] arb_wdata;
  logic [31:0]  arb_wbe;
  logic [255:0] rdata;
  logic         rvalid;
  logic         stall;
`ifdef MCPU_MEM_TLB_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  mcpu_mem_tlb #(.NUM_ENTRIES(8), .ENTRY_BITS(3)) dut (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst),
    .tlb_addr(addr), .tlb_re(re), .tlb_flags(flags), .tlb_phys_addr(phys),
    .tlb_ready(ready), .tlb_ptb(ptb), .tlb_paging_en(paging_en), .tlb_flush(flush),
    .tlb2arb_valid(arb_valid), .tlb2arb_opcode(arb_opcode), .tlb2arb_addr(arb_addr),
    .tlb2arb_wdata(arb_wdata), .tlb2arb_wbe(arb_wbe), .tlb2arb_rdata(rdata),
    .tlb2arb_rvalid(rvalid),
`ifdef MCPU_MEM_TLB_STATS_EN
    .tlb_hit_count(hit_count), .tlb_miss_count(miss_count),
`endif
    .tlb2arb_stall(stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory / arbiter model ----------------
  bit [31:0] mem [bit [29:0]];
  int        resp_lat = 0;
  int        atoms = 0;
  int        stable_err = 0;
  bit [26:0] atom_addrs [$];

  function automatic bit [31:0] rd(bit [29:0] w);
    return mem.exists(w) ? mem[w] : 32'h0;
  endfunction

  initial begin
    bit [26:0] a;
    rvalid = 1'b0; rdata = '0; stall = 1'b0;
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      if (arb_valid === 1'b1 && rst === 1'b0) begin
        a = arb_addr;
        for (int i = 0; i < resp_lat; i++) begin
          stall = 1'b1;
          @(negedge clk);
          if (arb_valid !== 1'b1 || arb_addr !== a) stable_err++;
        end
        stall = 1'b0;
        for (int w = 0; w < 8; w++) rdata[w*32 +: 32] = rd({a, w[2:0]});
        rvalid = 1'b1;
        atoms++;
        atom_addrs.push_back(a);
      end
    end
  end

  // ---------------- reference model: FIFO of installed translations ----------------
  typedef struct { bit [19:0] va; bit [19:0] ppn; bit [3:0] flg; } ent_t;
  ent_t cache [$];

  function automatic void predict(input bit [19:0] va, input bit pg, input bit fl,
                                  output bit [19:0] ph, output bit [3:0] f,
                                  output int na, output bit walk);
    bit [31:0] l1, l2;
    ent_t e;
    ph = va; f = 4'hF; na = 0; walk = 0;
    if (!pg) return;
    foreach (cache[i]) if (cache[i].va == va) begin
      ph = cache[i].ppn; f = cache[i].flg;
      return;
    end
    walk = 1;
    l1 = rd({ptb, va[19:10]});
    if (!l1[0]) begin
      ph = 0; f = 0; na = 1;
    end else begin
      l2 = rd({l1[31:12], va[9:0]});
      na = 2; ph = l2[31:12]; f = l2[3:0];
      if (l2[0] && !fl) begin
        e.va = va; e.ppn = l2[31:12]; e.flg = l2[3:0];
        cache.push_back(e);
        if (cache.size() > 8) void'(cache.pop_front());
      end
    end
    if (fl) cache.delete();
  endfunction

  task automatic map(input bit [19:0] va, input bit [31:0] l1, input bit [31:0] l2);
    mem[{ptb, va[19:10]}] = l1;
    mem[{l1[31:12], va[9:0]}] = l2;
  endtask

  // Drive one lookup and report what the DUT returned; no checking here.
  task automatic lookup(input bit [19:0] va, input bit use_flush, input bit [26:0] flush_line,
                        output bit [19:0] o_ph, output bit [3:0] o_f,
                        output int cyc, output int na, output bit tmo);
    int a0;
    bit fl_done;
    @(negedge clk);
    re = 1'b1; addr = va; a0 = atoms; cyc = 0; fl_done = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (use_flush && !fl_done && arb_valid === 1'b1 && arb_addr === flush_line) begin
        flush = 1'b1; fl_done = 1;
      end
    end while (ready !== 1'b1 && cyc < 400);
    re = 1'b0;
    flush = 1'b0;
    tmo = (ready !== 1'b1);
    o_ph = phys; o_f = flags; na = atoms - a0;
  endtask

  task automatic idle_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    cache.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; re = 0; addr = 0; ptb = 0; paging_en = 0; flush = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (phys !== 20'h0) begin n_fail++; $display("FAIL reset_phys got %h want 0", phys); end
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h want 0", flags); end
    n_checks++; if (arb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", arb_valid); end
    n_checks++; if (arb_opcode !== 3'd0 || arb_wdata !== '0 || arb_wbe !== '0) begin
      n_fail++; $display("FAIL reset_const_outputs got op=%h wbe=%h want 0", arb_opcode, arb_wbe);
    end
  endtask

  task automatic test_identity();
    bit [19:0] ph; bit [3:0] f; int cyc, na; bit tmo;
    paging_en = 0;
    lookup(20'h12345, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (ph !== 20'h12345) begin n_fail++; $display("FAIL ident_phys got %h want 12345", ph); end
    n_checks++; if (f !== 4'hF) begin n_fail++; $display("FAIL ident_flags got %h want f", f); end
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL ident_latency got %0d want 1", cyc); end
    n_checks++; if (na !== 0) begin n_fail++; $display("FAIL ident_atoms got %0d want 0", na); end
  endtask

  task automatic test_walk_hit();
    bit [19:0] ph, eph; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk;
    bit [19:0] va = 20'h12345;
    paging_en = 1; ptb = 20'h00100;
    map(va, 32'h0020_0001, 32'hABCD_E00F);
    atom_addrs.delete();
    predict(va, 1, 0, eph, ef, ena, walk);
    lookup(va, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL walk_timeout got ready=%b want 1", ready); end
    n_checks++; if (ph !== 20'hABCDE || ph !== eph) begin n_fail++; $display("FAIL walk_phys got %h want abcde", ph); end
    n_checks++; if (f !== 4'hF) begin n_fail++; $display("FAIL walk_flags got %h want f", f); end
    n_checks++; if (na !== 2) begin n_fail++; $display("FAIL walk_atoms got %0d want 2", na); end
    n_checks++; if (cyc <= 1) begin n_fail++; $display("FAIL walk_ready_low got latency %0d want >1", cyc); end
    n_checks++; if (atom_addrs.size() != 2 || atom_addrs[0] !== {20'h00100, va[19:13]} ||
                    atom_addrs[1] !== {20'h00200, va[9:3]}) begin
      n_fail++; $display("FAIL walk_atom_addr got %0d atoms first=%h want %h", atom_addrs.size(),
                         atom_addrs.size() ? atom_addrs[0] : 27'h0, {20'h00100, va[19:13]});
    end
    predict(va, 1, 0, eph, ef, ena, walk);
    lookup(va, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (walk || ph !== eph || f !== ef) begin n_fail++; $display("FAIL hit_result got %h/%h want %h/%h", ph, f, eph, ef); end
    n_checks++; if (cyc !== 1 || na !== 0) begin n_fail++; $display("FAIL hit_latency got cyc=%0d atoms=%0d want 1/0", cyc, na); end
  endtask

  task automatic test_l1_fault();
    bit [19:0] ph, eph; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk;
    bit [19:0] va = 20'h00ABC;
    mem[{ptb, va[19:10]}] = 32'h0030_0000;
    for (int k = 0; k < 2; k++) begin
      predict(va, 1, 0, eph, ef, ena, walk);
      lookup(va, 0, '0, ph, f, cyc, na, tmo);
      n_checks++; if (tmo || ph !== 20'h0 || f !== 4'h0 || ph !== eph) begin
        n_fail++; $display("FAIL fault_result pass %0d got %h/%h want 0/0", k, ph, f);
      end
      n_checks++; if (na !== 1 || na !== ena) begin n_fail++; $display("FAIL fault_atoms pass %0d got %0d want 1", k, na); end
    end
  endtask

  task automatic test_wrap();
    bit [19:0] ph, eph; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk;
    bit [19:0] va;
    idle_flush();
    for (int i = 0; i < 9; i++) begin
      va = 20'h40000 + 20'(i);
      map(va, 32'h0040_0001, {20'h50000 + 20'(i), 12'h007});
    end
    for (int i = 0; i < 9; i++) begin
      va = 20'h40000 + 20'(i);
      predict(va, 1, 0, eph, ef, ena, walk);
      lookup(va, 0, '0, ph, f, cyc, na, tmo);
      n_checks++; if (tmo || na !== 2 || ph !== eph || f !== ef) begin
        n_fail++; $display("FAIL wrap_fill page %0d got %h/%h atoms=%0d want %h/%h atoms=2", i, ph, f, na, eph, ef);
      end
    end
    for (int i = 1; i < 9; i++) begin
      va = 20'h40000 + 20'(i);
      predict(va, 1, 0, eph, ef, ena, walk);
      lookup(va, 0, '0, ph, f, cyc, na, tmo);
      n_checks++; if (walk || cyc !== 1 || na !== 0 || ph !== 20'h50000 + 20'(i)) begin
        n_fail++; $display("FAIL wrap_hit page %0d got %h cyc=%0d atoms=%0d want %h hit", i, ph, cyc, na, eph);
      end
    end
    predict(20'h40000, 1, 0, eph, ef, ena, walk);
    lookup(20'h40000, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (!walk || na !== 2 || ph !== 20'h50000) begin
      n_fail++; $display("FAIL wrap_evict got atoms=%0d phys=%h want 2/50000", na, ph);
    end
  endtask

  task automatic test_flush_walk();
    bit [19:0] ph, eph; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk;
    bit [19:0] va = 20'h60123;
    map(va, 32'h0061_0001, 32'h7777_7005);
    resp_lat = 2;
    predict(va, 1, 1, eph, ef, ena, walk);
    lookup(va, 1, {20'h00610, va[9:3]}, ph, f, cyc, na, tmo);
    n_checks++; if (tmo || ph !== 20'h77777 || f !== 4'h5 || na !== 2) begin
      n_fail++; $display("FAIL flush_result got %h/%h atoms=%0d want 77777/5 atoms=2", ph, f, na);
    end
    predict(va, 1, 0, eph, ef, ena, walk);
    lookup(va, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (na !== 2 || ph !== eph) begin n_fail++; $display("FAIL flush_same_page got atoms=%0d want 2", na); end
    predict(20'h40003, 1, 0, eph, ef, ena, walk);
    lookup(20'h40003, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (na !== 2 || ph !== 20'h50003) begin n_fail++; $display("FAIL flush_prior_page got atoms=%0d phys=%h want 2/50003", na, ph); end
    resp_lat = 0;
  endtask

  task automatic test_latency();
    bit [19:0] ph, eph; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk;
    bit [19:0] va = 20'h70001;
    map(va, 32'h0071_0001, 32'h1234_5003);
    resp_lat = 20; stable_err = 0;
    predict(va, 1, 0, eph, ef, ena, walk);
    lookup(va, 0, '0, ph, f, cyc, na, tmo);
    n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL lat_stable got %0d unstable cycles want 0", stable_err); end
    n_checks++; if (cyc <= 40) begin n_fail++; $display("FAIL lat_ready_low got latency %0d want >40", cyc); end
    n_checks++; if (tmo || ph !== 20'h12345 || f !== 4'h3 || ph !== eph) begin
      n_fail++; $display("FAIL lat_result got %h/%h want 12345/3", ph, f);
    end
    resp_lat = 0;
  endtask

  task automatic test_reset_mid_walk();
    bit [19:0] va = 20'h70555;
    map(va, 32'h0072_0001, 32'h2222_2001);
    resp_lat = 20;
    @(negedge clk); re = 1'b1; addr = va;
    @(posedge clk);
    repeat (4) @(negedge clk);
    n_checks++; if (arb_valid !== 1'b1 || ready !== 1'b0) begin
      n_fail++; $display("FAIL rstwalk_busy got valid=%b ready=%b want 1/0", arb_valid, ready);
    end
    re = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (arb_valid !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rstwalk_async got valid=%b ready=%b want 0/1", arb_valid, ready);
    end
    @(negedge clk); rst = 1'b0;
    repeat (25) @(negedge clk);
    n_checks++; if (arb_valid !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL rstwalk_late_rvalid got valid=%b ready=%b want 0/1", arb_valid, ready);
    end
    cache.delete(); resp_lat = 0; stable_err = 0;
  endtask

  task automatic test_random();
    bit [19:0] pool [12];
    bit [19:0] ph, eph, va; bit [3:0] f, ef; int cyc, na, ena; bit tmo, walk, pg;
    ptb = 20'h0A000;
    idle_flush();
    for (int i = 0; i < 12; i++) begin
      pool[i] = 20'h80000 + 20'(i * 1031);
      map(pool[i], {20'h0B000 + 20'($urandom_range(0, 3)), 11'h0, 1'($urandom_range(0, 5) != 0)},
          {20'($urandom), 8'h0, 4'($urandom) | 4'($urandom_range(0, 4) != 0)});
    end
    for (int n = 0; n < 60; n++) begin
      va = pool[$urandom_range(0, 11)];
      pg = ($urandom_range(0, 5) != 0);
      resp_lat = $urandom_range(0, 3);
      paging_en = pg;
      if ($urandom_range(0, 9) == 0) idle_flush();
      predict(va, pg, 0, eph, ef, ena, walk);
      lookup(va, 0, '0, ph, f, cyc, na, tmo);
      n_checks++; if (tmo || ph !== eph || f !== ef || na !== ena || (walk ? cyc <= 1 : cyc !== 1)) begin
        n_fail++; $display("FAIL rand_lookup n=%0d va=%h got %h/%h atoms=%0d cyc=%0d want %h/%h atoms=%0d walk=%0d",
                           n, va, ph, f, na, cyc, eph, ef, ena, walk);
      end
    end
    resp_lat = 0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_walk_hit();
    test_l1_fault();
    test_wrap();
    test_flush_walk();
    test_latency();
    test_reset_mid_walk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
